// File: rtl/shift_arb_pkg.sv
// Shared constants, buffer state encoding and round-robin helper for shift_arbiter.
package shift_arb_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_NREQ  = 4;

   // One-entry output buffer occupancy
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_e;

   // Increment a round-robin pointer with an explicit wrap (nreq need not be a power of two)
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
      return ((ptr + 32'd1) >= nreq) ? 32'd0 : (ptr + 32'd1);
   endfunction

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational left barrel shifter, log2(WIDTH) stages.
// Optional rotate mode when SHIFT_ARB_ROTATE_EN is defined.
module barrel_shift_core
   import shift_arb_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] in,
   input  logic [SHW-1:0]   shft,
`ifdef SHIFT_ARB_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] stage;
   logic [SHW-1:0]   amt_bits;

   // Stage i moves the operand by (1<<i) when amount bit i is set
   always_comb begin
      stage    = in;
      amt_bits = shft;
      for (int unsigned i = 0; i < SHW; i++) begin
         if (amt_bits[0]) begin
`ifdef SHIFT_ARB_ROTATE_EN
            if (rot) begin
               stage = (stage << (1 << i)) | (stage >> (WIDTH - (1 << i)));
            end else begin
               stage = stage << (1 << i);
            end
`else
            stage = stage << (1 << i);
`endif
         end
         amt_bits = amt_bits >> 1;
      end
      out = stage;
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NREQ requesters,
// with a one-entry registered output buffer.
// Optional macro: SHIFT_ARB_ROTATE_EN adds req_rot for per-request rotate.
module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned NREQ  = DEF_NREQ,
   localparam int unsigned SHW   = $clog2(WIDTH),
   localparam int unsigned IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ*SHW-1:0]   req_shft,
`ifdef SHIFT_ARB_ROTATE_EN
   input  logic [NREQ-1:0]       req_rot,
`endif
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [IDW-1:0]        rsp_id
);

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

   logic [WIDTH-1:0] data_arr [NREQ];
   logic [SHW-1:0]   shft_arr [NREQ];
   logic             grant_found;
   logic [IDW-1:0]   grant_idx;
   logic [IDW:0]     search_idx;
   logic             can_accept;
   logic             accept;
   logic [WIDTH-1:0] shifted;

   // Unpack per-requester operands
   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign data_arr[k] = req_data[k*WIDTH +: WIDTH];
      assign shft_arr[k] = req_shft[k*SHW +: SHW];
   end

   // Round-robin search from rr_ptr upward, wrapping at NREQ
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      search_idx  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         search_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (search_idx >= (IDW+1)'(NREQ)) begin
            search_idx = search_idx - (IDW+1)'(NREQ);
         end
         if (!grant_found && req_valid[search_idx[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = search_idx[IDW-1:0];
         end
      end
   end

   assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
   assign accept     = grant_found & can_accept;

   // One-hot ready to the granted requester only
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   barrel_shift_core #(.WIDTH(WIDTH)) u_core (
      .in   (data_arr[grant_idx]),
      .shft (shft_arr[grant_idx]),
`ifdef SHIFT_ARB_ROTATE_EN
      .rot  (req_rot[grant_idx]),
`endif
      .out  (shifted)
   );

   // Buffer FSM next state, result capture and pointer advance
   always_comb begin
      state_d    = state_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
      endcase
      if (accept) begin
         rsp_data_d = shifted;
         rsp_id_d   = grant_idx;
         rr_ptr_d   = IDW'(rr_next(32'(grant_idx), NREQ));
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (WIDTH=8, NREQ=4).
module tb_shift_arbiter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned SHW   = 3;
   localparam int unsigned IDW   = 2;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ*SHW-1:0]   req_shft;
`ifdef SHIFT_ARB_ROTATE_EN
   logic [NREQ-1:0]       req_rot;
`endif
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WIDTH-1:0]      rsp_data;
   logic [IDW-1:0]        rsp_id;

   logic [WIDTH-1:0] d [NREQ];
   logic [SHW-1:0]   s [NREQ];

   int tests;
   int fails;

   for (genvar k = 0; k < NREQ; k++) begin : g_pack
      assign req_data[k*WIDTH +: WIDTH] = d[k];
      assign req_shft[k*SHW +: SHW]     = s[k];
   end

   shift_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_shft  (req_shft),
`ifdef SHIFT_ARB_ROTATE_EN
      .req_rot   (req_rot),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [7:0] dat, input logic [1:0] id);
      chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
      chk({tag, ".data"},  32'(rsp_data),  32'(dat));
      chk({tag, ".id"},    32'(rsp_id),    32'(id));
   endtask

   logic [7:0] fair_exp [NREQ];

   initial begin
      tests     = 0;
      fails     = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
`ifdef SHIFT_ARB_ROTATE_EN
      req_rot   = '0;
`endif
      for (int k = 0; k < 4; k++) begin
         d[k] = 8'h0F;
         s[k] = 3'(k);
      end
      fair_exp[0] = 8'h0F;
      fair_exp[1] = 8'h1E;
      fair_exp[2] = 8'h3C;
      fair_exp[3] = 8'h78;

      // Reset state
      step();
      step();
      #1;
      chk_rsp("reset", 1'b0, 8'h00, 2'd0);
      chk("reset.ready", 32'(req_ready), 32'h0);
      rst_n = 1'b1;
      step();

      // Fairness: all requesters valid, downstream always ready
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("fair.ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
         step();
         chk_rsp("fair", 1'b1, fair_exp[i % 4], 2'(i % 4));
      end
      req_valid = '0;
      step();
      chk("drain.valid", 32'(rsp_valid), 32'h0);

      // Single requester, maximum shift
      d[0] = 8'b1001_1101;
      s[0] = 3'd7;
      req_valid = 4'b0001;
      #1;
      chk("single.ready", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      chk_rsp("single", 1'b1, 8'b1000_0000, 2'd0);

      // Pass-through on the last requester (pointer now 1, wraps to 0 after)
      d[3] = 8'hA5;
      s[3] = 3'd0;
      req_valid = 4'b1000;
      #1;
      chk("pass.ready", 32'(req_ready), 32'h8);
      step();
      req_valid = '0;
      chk_rsp("pass", 1'b1, 8'hA5, 2'd3);

      // Search restarts at 0: req0 beats req2
      req_valid = 4'b0101;
      #1;
      chk("wrap.ready", 32'(req_ready), 32'h1);
      step();
      chk_rsp("wrap", 1'b1, 8'h80, 2'd0);

      // Backpressure: req1 waits while the buffer is held
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp.ready", 32'(req_ready), 32'h0);
         step();
         chk_rsp("bp", 1'b1, 8'h80, 2'd0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release.ready", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      chk_rsp("bp_release", 1'b1, 8'h1E, 2'd1);

      // Hold a result, then reset asynchronously between edges (pointer was 2)
      rsp_ready = 1'b0;
      step();
      chk("prereset.valid", 32'(rsp_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_rsp("async_reset", 1'b0, 8'h00, 2'd0);
      rst_n = 1'b1;
      #1;
      req_valid = 4'b0101;
      rsp_ready = 1'b1;
      #1;
      chk("postreset.ready", 32'(req_ready), 32'h1);
      step();
      chk_rsp("postreset", 1'b1, 8'h80, 2'd0);
      req_valid = 4'b0100;
      #1;
      chk("postreset2.ready", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      chk_rsp("postreset2", 1'b1, 8'h3C, 2'd2);
      step();
      chk("idle.valid", 32'(rsp_valid), 32'h0);

`ifdef SHIFT_ARB_ROTATE_EN
      // Rotate vs shift on req0
      d[0] = 8'b1001_1101;
      s[0] = 3'd3;
      req_rot = 4'b0001;
      req_valid = 4'b0001;
      step();
      chk_rsp("rotate", 1'b1, 8'b1110_1100, 2'd0);
      req_rot = 4'b0000;
      step();
      req_valid = '0;
      chk_rsp("norotate", 1'b1, 8'b1110_1000, 2'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
